// File: rtl/logic_pipe.sv
// logic_pipe: DEPTH-stage valid/ready register pipeline over CHANNELS x WIDTH
// bit channels. Each stage optionally stores the bitwise inverse of its input
// (INVERT_MASK[i]), and the output may be OR-reduced across channels into
// channel 0 (OR_REDUCE). Stages compact forward into empty slots, so the pipe
// streams one word per cycle while downstream is ready and fills completely
// under backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous reset, active HIGH despite the name
//   in_valid   upstream word valid
//   in_ready   stage 0 can take a word this cycle (independent of in_valid)
//   in_data    CHANNELS*WIDTH input word, channel c at [c*WIDTH +: WIDTH]
//   out_valid  last stage holds a word
//   out_ready  downstream accepts the word
//   out_data   last-stage word (or its OR-reduced form)
//   occupancy  registered count of valid stages
//   xfer_count completed output transfers, modulo 2^16
module logic_pipe #(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      CHANNELS    = 2,
    parameter int unsigned      DEPTH       = 3,
    parameter logic [DEPTH-1:0] INVERT_MASK = '1,
    parameter bit               OR_REDUCE   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*WIDTH-1:0]  in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*WIDTH-1:0]  out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                xfer_count
);

    localparam int unsigned DW = CHANNELS * WIDTH;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0]         valid_d;
    logic [DEPTH-1:0]         advance;
    logic [DEPTH-1:0]         load;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [OW-1:0]            occ_q;
    logic [OW-1:0]            occ_d;
    logic [15:0]              xfer_q;

    // A stage may move on when its successor is empty or moving on itself;
    // evaluated from the output end backwards so each stage sees its
    // successor's decision.
    always_comb begin
        logic carry;
        advance = '0;
        carry   = valid_q[DEPTH-1] & out_ready;
        advance[DEPTH-1] = carry;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            carry = valid_q[DEPTH-1-k] & (~valid_q[DEPTH-k] | carry);
            advance[DEPTH-1-k] = carry;
        end
    end

    assign in_ready  = ~valid_q[0] | advance[0];
    assign out_valid = valid_q[DEPTH-1];

    always_comb begin
        load    = '0;
        valid_d = '0;
        occ_d   = '0;
        load[0] = in_valid & in_ready;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            load[i] = advance[i-1];
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_d[i] = load[i] | (valid_q[i] & ~advance[i]);
            occ_d      = occ_d + OW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            valid_q <= '0;
            data_q  <= '0;
            occ_q   <= '0;
            xfer_q  <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            if (out_valid & out_ready) begin
                xfer_q <= xfer_q + 16'd1;
            end
            if (load[0]) begin
                data_q[0] <= in_data ^ {DW{INVERT_MASK[0]}};
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (load[i]) begin
                    data_q[i] <= data_q[i-1] ^ {DW{INVERT_MASK[i]}};
                end
            end
        end
    end

    generate
        if (OR_REDUCE) begin : g_or_reduce
            // Combinational OR across channels of the last stage, placed in
            // channel 0; the upper channels read as zero.
            logic [WIDTH-1:0] reduced;
            always_comb begin
                reduced = '0;
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    reduced = reduced | data_q[DEPTH-1][c*WIDTH +: WIDTH];
                end
                out_data = DW'(reduced);
            end
        end else begin : g_pass
            assign out_data = data_q[DEPTH-1];
        end
    endgenerate

    assign occupancy  = occ_q;
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_logic_pipe.sv
// Directed bench for logic_pipe using three instances:
//   u_inv  : defaults, INVERT_MASK=3'b111 (three inversions, net invert)
//   u_even : INVERT_MASK=3'b101 (net identity)
//   u_or   : WIDTH=4, CHANNELS=3, INVERT_MASK=0, OR_REDUCE=1
module tb_logic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_in_data, a_out_data, a_occ;
    logic [15:0] a_xfer;

    logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0]  b_in_data, b_out_data, b_occ;
    logic [15:0] b_xfer;

    logic        c_rst, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [11:0] c_in_data, c_out_data;
    logic [1:0]  c_occ;
    logic [15:0] c_xfer;

    logic_pipe #(.WIDTH(1), .CHANNELS(2), .DEPTH(3), .INVERT_MASK(3'b111), .OR_REDUCE(1'b0)) u_inv (
        .clk(clk), .rstn(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .xfer_count(a_xfer));

    logic_pipe #(.WIDTH(1), .CHANNELS(2), .DEPTH(3), .INVERT_MASK(3'b101), .OR_REDUCE(1'b0)) u_even (
        .clk(clk), .rstn(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .xfer_count(b_xfer));

    logic_pipe #(.WIDTH(4), .CHANNELS(3), .DEPTH(3), .INVERT_MASK(3'b000), .OR_REDUCE(1'b1)) u_or (
        .clk(clk), .rstn(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ), .xfer_count(c_xfer));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_inv();
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_rst = 1'b1;
        #1;
        a_rst = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 2'b11; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0;    b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0;    c_out_ready = 1'b0;
        tick(); tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid actual=%0h expected=0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready actual=%0h expected=1", a_in_ready); end
        checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL rst_occupancy actual=%0h expected=0", a_occ); end
        checks++; if (a_xfer !== 16'd0) begin failures++; $display("FAIL rst_xfer_count actual=%0h expected=0", a_xfer); end
        checks++; if (a_out_data !== 2'b00) begin failures++; $display("FAIL rst_out_data actual=%0h expected=0", a_out_data); end
        a_in_valid = 1'b0;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL post_rst_out_valid actual=%0h expected=0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready actual=%0h expected=1", a_in_ready); end
    endtask

    task automatic test_latency();
        a_out_ready = 1'b1;
        a_in_data = 2'b01; a_in_valid = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL lat_in_ready actual=%0h expected=1", a_in_ready); end
        tick();
        a_in_valid = 1'b0; a_in_data = 2'b11;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL lat_edge0_valid actual=%0h expected=0", a_out_valid); end
        checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL lat_edge0_occ actual=%0h expected=1", a_occ); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL lat_edge1_valid actual=%0h expected=0", a_out_valid); end
        tick();
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL lat_edge2_valid actual=%0h expected=1", a_out_valid); end
        checks++; if (a_out_data !== 2'b10) begin failures++; $display("FAIL lat_out_data actual=%0h expected=2", a_out_data); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL lat_drained_valid actual=%0h expected=0", a_out_valid); end
        checks++; if (a_xfer !== 16'd1) begin failures++; $display("FAIL lat_xfer_count actual=%0h expected=1", a_xfer); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_even_inversion();
        int exp_occ [8] = '{1, 2, 3, 3, 2, 1, 0, 0};
        logic exp_v;
        b_out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            b_in_valid = (n < 4);
            b_in_data  = 2'(n);
            #1;
            checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL even_in_ready n=%0d actual=%0h expected=1", n, b_in_ready); end
            tick();
            exp_v = (n >= 2 && n <= 5);
            checks++; if (b_out_valid !== exp_v) begin failures++; $display("FAIL even_out_valid edge=%0d actual=%0h expected=%0h", n + 1, b_out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (b_out_data !== 2'(n - 2)) begin failures++; $display("FAIL even_out_data edge=%0d actual=%0h expected=%0h", n + 1, b_out_data, 2'(n - 2)); end
            end
            checks++; if (b_occ !== 2'(exp_occ[n])) begin failures++; $display("FAIL even_occupancy edge=%0d actual=%0h expected=%0h", n + 1, b_occ, exp_occ[n]); end
        end
        checks++; if (b_xfer !== 16'd4) begin failures++; $display("FAIL even_xfer_count actual=%0h expected=4", b_xfer); end
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_out [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
        int idx = 0;
        reset_inv();
        for (int n = 0; n < 3; n++) begin
            a_in_valid = 1'b1; a_in_data = 2'(n + 1);
            #1;
            checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_fill_ready n=%0d actual=%0h expected=1", n, a_in_ready); end
            tick();
        end
        a_in_data = 2'b00;
        #1;
        checks++; if (a_occ !== 2'd3) begin failures++; $display("FAIL bp_full_occ actual=%0h expected=3", a_occ); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready actual=%0h expected=0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_full_out_valid actual=%0h expected=1", a_out_valid); end
        checks++; if (a_out_data !== 2'b10) begin failures++; $display("FAIL bp_full_out_data actual=%0h expected=2", a_out_data); end
        for (int h = 0; h < 2; h++) begin
            tick();
            checks++; if (a_out_data !== 2'b10) begin failures++; $display("FAIL bp_hold_out_data h=%0d actual=%0h expected=2", h, a_out_data); end
            checks++; if (a_occ !== 2'd3) begin failures++; $display("FAIL bp_hold_occ h=%0d actual=%0h expected=3", h, a_occ); end
        end
        a_out_ready = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_pop_push_ready actual=%0h expected=1", a_in_ready); end
        for (int c = 0; c < 10 && idx < 4; c++) begin
            if (a_out_valid) begin
                checks++; if (a_out_data !== exp_out[idx]) begin failures++; $display("FAIL bp_order idx=%0d actual=%0h expected=%0h", idx, a_out_data, exp_out[idx]); end
                idx++;
            end
            tick();
            a_in_valid = 1'b0;
        end
        checks++; if (idx !== 4) begin failures++; $display("FAIL bp_word_count actual=%0d expected=4", idx); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained_valid actual=%0h expected=0", a_out_valid); end
        checks++; if (a_xfer !== 16'd4) begin failures++; $display("FAIL bp_xfer_count actual=%0h expected=4", a_xfer); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_or_reduce();
        logic [11:0] vec [3] = '{12'h128, 12'h400, 12'h35A};
        logic [11:0] exp [3] = '{12'h00B, 12'h004, 12'h00F};
        c_out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            c_in_valid = 1'b1; c_in_data = vec[n];
            tick();
        end
        c_in_valid = 1'b0; c_in_data = 12'hFFF;
        for (int n = 0; n < 3; n++) begin
            checks++; if (c_out_valid !== 1'b1) begin failures++; $display("FAIL or_out_valid n=%0d actual=%0h expected=1", n, c_out_valid); end
            checks++; if (c_out_data !== exp[n]) begin failures++; $display("FAIL or_out_data n=%0d actual=%03h expected=%03h", n, c_out_data, exp[n]); end
            tick();
        end
        checks++; if (c_out_valid !== 1'b0) begin failures++; $display("FAIL or_drained_valid actual=%0h expected=0", c_out_valid); end
    endtask

    task automatic test_reset_midstream();
        reset_inv();
        a_in_valid = 1'b1; a_in_data = 2'b01; tick();
        a_in_data = 2'b10; tick();
        a_in_valid = 1'b0; tick();
        checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL mid_pre_occ actual=%0h expected=2", a_occ); end
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid actual=%0h expected=1", a_out_valid); end
        #2;
        a_rst = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid actual=%0h expected=0", a_out_valid); end
        checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL mid_rst_occ actual=%0h expected=0", a_occ); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready actual=%0h expected=1", a_in_ready); end
        #1;
        a_rst = 1'b0;
        a_out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_word n=%0d actual=%0h expected=0", n, a_out_valid); end
        end
        checks++; if (a_xfer !== 16'd0) begin failures++; $display("FAIL mid_xfer_count actual=%0h expected=0", a_xfer); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int   n   = 0;
        int   cyc = 0;
        logic will_xfer;
        reset_inv();
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        while (n < 65537 && cyc < 70000) begin
            will_xfer = a_out_valid;
            a_in_data = 2'(cyc);
            tick();
            cyc++;
            if (will_xfer) begin
                n++;
                if (n == 65535) begin
                    checks++; if (a_xfer !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff actual=%0h expected=ffff", a_xfer); end
                end
                if (n == 65536) begin
                    checks++; if (a_xfer !== 16'h0000) begin failures++; $display("FAIL wrap_zero actual=%0h expected=0", a_xfer); end
                end
            end
        end
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        checks++; if (n !== 65537) begin failures++; $display("FAIL wrap_transfers actual=%0d expected=65537", n); end
        checks++; if (a_xfer !== 16'd1) begin failures++; $display("FAIL wrap_final actual=%0h expected=1", a_xfer); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_even_inversion();
        test_backpressure();
        test_or_reduce();
        test_reset_midstream();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
